// File: rtl/tdm_scan_mux.sv
// Registered N-channel TDM scanner: auto-steps through channels at a programmable
// prescaled rate or holds a manually chosen channel; drives data, one-hot strobe and wrap pulse.
module tdm_scan_mux #(
    parameter int DATA_WIDTH = 1,
    parameter int NUM_CH     = 4,
    parameter int SEL_WIDTH  = 2,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           enable,
    input  logic                           mode,
    input  logic [SEL_WIDTH-1:0]           manual_sel,
    input  logic [DIV_WIDTH-1:0]           div_limit,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   in_data,
    output logic [DATA_WIDTH-1:0]          out,
    output logic [SEL_WIDTH-1:0]           active_sel,
    output logic [NUM_CH-1:0]              ch_strobe,
    output logic                           wrap
);

    localparam logic [SEL_WIDTH:0]   CH_CNT   = (SEL_WIDTH+1)'(NUM_CH);
    localparam logic [SEL_WIDTH-1:0] LAST_SEL = SEL_WIDTH'(NUM_CH - 1);

    logic [DIV_WIDTH-1:0]  cnt_q, cnt_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic [DATA_WIDTH-1:0] out_q, out_d;
    logic [NUM_CH-1:0]     strobe_q, strobe_d;
    logic                  wrap_q, wrap_d;
    logic                  tick;

    logic [DATA_WIDTH-1:0] ch [NUM_CH];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
        assign ch[k] = in_data[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // Unsigned >= so that lowering div_limit below the running count ticks at once.
    assign tick = (cnt_q >= div_limit);

    always_comb begin
        cnt_d  = cnt_q;
        sel_d  = sel_q;
        wrap_d = 1'b0;
        if (mode) begin
            cnt_d = '0;
            if ({1'b0, manual_sel} < CH_CNT) begin
                sel_d = manual_sel;
            end
        end else if (enable) begin
            if (tick) begin
                cnt_d = '0;
                if (sel_q == LAST_SEL) begin
                    sel_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    sel_d = sel_q + 1'b1;
                end
            end else begin
                cnt_d = cnt_q + DIV_WIDTH'(1);
            end
        end
        strobe_d = NUM_CH'(1) << sel_d;
        // Data path samples the select already in place, so it lags a select change by one cycle.
        out_d    = ch[sel_q];
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            sel_q    <= '0;
            out_q    <= '0;
            strobe_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            out_q    <= out_d;
            strobe_q <= strobe_d;
            wrap_q   <= wrap_d;
        end
    end

    assign out        = out_q;
    assign active_sel = sel_q;
    assign ch_strobe  = strobe_q;
    assign wrap       = wrap_q;

endmodule

// File: tb/tb_tdm_scan_mux.sv
// Directed bench for tdm_scan_mux: a 4-channel instance for scan/freeze/manual/reset
// and a 3-channel instance for the out-of-range manual select and 3-channel wrap.
module tb_tdm_scan_mux;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, enable, mode;
    logic [1:0]  manual_sel;
    logic [15:0] div_limit;
    logic [31:0] in_data;
    logic [7:0]  out;
    logic [1:0]  active_sel;
    logic [3:0]  ch_strobe;
    logic        wrap;

    logic        rst3_n, en3, mode3;
    logic [1:0]  msel3;
    logic [15:0] div3;
    logic [23:0] in3;
    logic [7:0]  out3;
    logic [1:0]  sel3;
    logic [2:0]  strobe3;
    logic        wrap3;

    int tests_run = 0;
    int tests_failed = 0;

    tdm_scan_mux #(.DATA_WIDTH(8), .NUM_CH(4), .SEL_WIDTH(2), .DIV_WIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .mode(mode),
        .manual_sel(manual_sel), .div_limit(div_limit), .in_data(in_data),
        .out(out), .active_sel(active_sel), .ch_strobe(ch_strobe), .wrap(wrap)
    );

    tdm_scan_mux #(.DATA_WIDTH(8), .NUM_CH(3), .SEL_WIDTH(2), .DIV_WIDTH(16)) dut3 (
        .clk(clk), .reset_n(rst3_n), .enable(en3), .mode(mode3),
        .manual_sel(msel3), .div_limit(div3), .in_data(in3),
        .out(out3), .active_sel(sel3), .ch_strobe(strobe3), .wrap(wrap3)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; enable = 1'b1; mode = 1'b0; manual_sel = 2'd0;
        div_limit = 16'd2; in_data = {8'hDD, 8'hCC, 8'hBB, 8'hAA};
        rst3_n = 1'b0; en3 = 1'b1; mode3 = 1'b0; msel3 = 2'd0;
        div3 = 16'd1; in3 = {8'h63, 8'h62, 8'h61};
        #1;

        // Reset / idle
        step(2);
        check_eq("rst_out", out, 8'h00);
        check_eq("rst_sel", active_sel, 2'd0);
        check_eq("rst_strobe", ch_strobe, 4'b0000);
        check_eq("rst_wrap", wrap, 1'b0);
        reset_n = 1'b1;
        step(1);
        check_eq("first_strobe", ch_strobe, 4'b0001);
        check_eq("first_out", out, 8'hAA);

        // Auto scan, div_limit=2: step every 3 cycles
        step(2);
        check_eq("auto_sel1", active_sel, 2'd1);
        check_eq("auto_out_lag", out, 8'hAA);
        check_eq("auto_strobe1", ch_strobe, 4'b0010);
        step(1);
        check_eq("auto_out_bb", out, 8'hBB);
        step(2);
        check_eq("auto_sel2", active_sel, 2'd2);
        step(3);
        check_eq("auto_sel3", active_sel, 2'd3);
        check_eq("auto_nowrap", wrap, 1'b0);
        step(1);
        check_eq("auto_out_dd", out, 8'hDD);
        step(2);
        check_eq("auto_wrap_sel", active_sel, 2'd0);
        check_eq("auto_wrap", wrap, 1'b1);
        step(1);
        check_eq("auto_wrap_once", wrap, 1'b0);
        check_eq("auto_out_aa", out, 8'hAA);

        // div_limit=0: step every cycle, wrap every 4th
        div_limit = 16'd0;
        step(1);
        check_eq("div0_sel1", active_sel, 2'd1);
        step(3);
        check_eq("div0_sel0", active_sel, 2'd0);
        check_eq("div0_wrap", wrap, 1'b1);
        step(1);
        check_eq("div0_wrap_off", wrap, 1'b0);
        check_eq("div0_sel1b", active_sel, 2'd1);
        step(3);
        check_eq("div0_wrap2", wrap, 1'b1);

        // Count to 5 under div_limit=7, then lower to 1: immediate tick
        div_limit = 16'd7;
        step(5);
        check_eq("lower_hold", active_sel, 2'd0);
        div_limit = 16'd1;
        step(1);
        check_eq("lower_tick", active_sel, 2'd1);

        // Freeze with enable=0 mid-count
        div_limit = 16'd2;
        in_data[15:8] = 8'h11;
        step(1);
        check_eq("frz_out11", out, 8'h11);
        enable = 1'b0;
        step(3);
        check_eq("frz_sel", active_sel, 2'd1);
        in_data[15:8] = 8'h22;
        step(1);
        check_eq("frz_out22", out, 8'h22);
        step(6);
        check_eq("frz_sel_end", active_sel, 2'd1);
        check_eq("frz_wrap", wrap, 1'b0);
        enable = 1'b1;
        step(1);
        check_eq("resume_hold", active_sel, 2'd1);
        step(1);
        check_eq("resume_step", active_sel, 2'd2);

        // Manual mode, enable ignored
        mode = 1'b1; manual_sel = 2'd0;
        step(1);
        check_eq("man_sel0", active_sel, 2'd0);
        manual_sel = 2'd2; enable = 1'b0;
        step(1);
        check_eq("man_sel2", active_sel, 2'd2);
        check_eq("man_strobe", ch_strobe, 4'b0100);
        step(1);
        check_eq("man_out", out, 8'hCC);
        check_eq("man_wrap", wrap, 1'b0);

        // Back to auto: first step after div_limit+1 cycles
        mode = 1'b0; enable = 1'b1;
        step(2);
        check_eq("resume_auto_hold", active_sel, 2'd2);
        step(1);
        check_eq("resume_auto_step", active_sel, 2'd3);

        // Reset on the edge that would wrap 3->0
        step(2);
        reset_n = 1'b0;
        step(1);
        check_eq("mid_rst_sel", active_sel, 2'd0);
        check_eq("mid_rst_strobe", ch_strobe, 4'b0000);
        check_eq("mid_rst_out", out, 8'h00);
        check_eq("mid_rst_wrap", wrap, 1'b0);
        reset_n = 1'b1;
        step(1);
        check_eq("post_rst_wrap", wrap, 1'b0);
        check_eq("post_rst_strobe", ch_strobe, 4'b0001);

        // 3-channel instance: out-of-range manual select holds
        rst3_n = 1'b1; mode3 = 1'b1; msel3 = 2'd2;
        step(1);
        check_eq("c3_sel2", sel3, 2'd2);
        check_eq("c3_strobe", strobe3, 3'b100);
        msel3 = 2'd3;
        step(2);
        check_eq("c3_hold", sel3, 2'd2);
        check_eq("c3_out", out3, 8'h63);
        mode3 = 1'b0;
        step(1);
        check_eq("c3_auto_hold", sel3, 2'd2);
        step(1);
        check_eq("c3_wrap_sel", sel3, 2'd0);
        check_eq("c3_wrap", wrap3, 1'b1);
        step(1);
        check_eq("c3_wrap_off", wrap3, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
